// File: rtl/mem_sram_ctrl.sv
// Word-to-halfword SRAM responder for the MEM stage: each 32-bit access is split
// into a low and a high 16-bit phase, each held WAIT_CYCLES+1 cycles.
module mem_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_en,
  input  logic               MEM_W_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [15:0]        wdata_hi_q, wdata_hi_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic        req;
  logic [31:0] off;
  logic        unused_off_bits;

  assign req             = MEM_R_en | MEM_W_en;
  assign off             = address - 32'(BASE_ADDR);
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};

  assign ready       = ~req | (state_q == DONE);
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    wdata_hi_d = wdata_hi_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    oe_d       = oe_q;
    we_n_d     = we_n_q;

    case (state_q)
      IDLE: begin
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (req) begin
          state_d    = LOW;
          cnt_d      = '0;
          is_wr_d    = MEM_W_en;
          wdata_hi_d = write_data[31:16];
          addr_d     = {off[SRAM_AW:2], 1'b0};
          if (MEM_W_en) begin
            dq_out_d = write_data[15:0];
            oe_d     = 1'b1;
            we_n_d   = 1'b0;
          end
        end
      end
      LOW, HIGH: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d = '0;
          if (!is_wr_q) begin
            if (state_q == LOW) rdata_d[15:0]  = sram_dq_in;
            else                rdata_d[31:16] = sram_dq_in;
          end
          if (state_q == LOW) begin
            state_d = HIGH;
            addr_d  = {addr_q[SRAM_AW-1:1], 1'b1};
            if (is_wr_q) begin
              dq_out_d = wdata_hi_q;
              we_n_d   = 1'b0;
            end
          end else begin
            state_d = DONE;
            oe_d    = 1'b0;
            we_n_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          // Strobe rises one cycle before the phase ends so data/address outlast it.
          we_n_d = ~is_wr_q | ((cnt_q + 4'd1) == WAIT_LAST);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        we_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      wdata_hi_q <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      oe_q       <= 1'b0;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      wdata_hi_q <= wdata_hi_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      oe_q       <= oe_d;
      we_n_q     <= we_n_d;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: default instance (WAIT_CYCLES=1) and a
// WAIT_CYCLES=3 instance, each backed by a small behavioural SRAM.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        ready, oe, we_n;
  logic [17:0] s_addr;
  logic [15:0] dq_out, dq_in;
  logic [15:0] mem [0:63];

  // WAIT_CYCLES=3 instance
  logic        r_en3 = 1'b0, w_en3 = 1'b0;
  logic [31:0] addr3 = '0, wdata3 = '0, rdata3;
  logic        ready3, oe3, we_n3;
  logic [17:0] s_addr3;
  logic [15:0] dq_out3, dq_in3;
  logic [15:0] mem3 [0:63];

  int unsigned checks = 0;
  int unsigned failures = 0;

  mem_sram_ctrl dut (
    .clk(clk), .rst(rst), .MEM_R_en(r_en), .MEM_W_en(w_en),
    .address(addr), .write_data(wdata), .read_data(rdata), .ready(ready),
    .sram_addr(s_addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
    .sram_dq_oe(oe), .sram_we_n(we_n)
  );

  mem_sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .MEM_R_en(r_en3), .MEM_W_en(w_en3),
    .address(addr3), .write_data(wdata3), .read_data(rdata3), .ready(ready3),
    .sram_addr(s_addr3), .sram_dq_out(dq_out3), .sram_dq_in(dq_in3),
    .sram_dq_oe(oe3), .sram_we_n(we_n3)
  );

  assign dq_in  = mem[s_addr[5:0]];
  assign dq_in3 = mem3[s_addr3[5:0]];

  always @(posedge clk) begin
    if (!we_n && oe)   mem[s_addr[5:0]]   <= dq_out;
    if (!we_n3 && oe3) mem3[s_addr3[5:0]] <= dq_out3;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of the cycle where the request first appears (controller idle).
  // lo is the expected low-half SRAM address; exp_rd the word a read must return.
  task automatic access(input string name, input bit d3, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input int unsigned w,
                        input logic [17:0] lo, input logic [31:0] exp_rd);
    int unsigned last_lo, last_hi, done_c, ph;
    logic        g_ready, g_oe, g_we_n;
    logic [17:0] g_addr;
    logic [15:0] g_dq;
    logic [31:0] g_rd;
    last_lo = w + 1;
    last_hi = 2 * w + 2;
    done_c  = 2 * w + 3;
    if (d3) begin r_en3 = rd; w_en3 = wr; addr3 = a; wdata3 = wd; end
    else    begin r_en  = rd; w_en  = wr; addr  = a; wdata  = wd; end
    for (int unsigned c = 0; c <= done_c; c++) begin
      @(negedge clk);
      g_ready = d3 ? ready3  : ready;
      g_oe    = d3 ? oe3     : oe;
      g_we_n  = d3 ? we_n3   : we_n;
      g_addr  = d3 ? s_addr3 : s_addr;
      g_dq    = d3 ? dq_out3 : dq_out;
      g_rd    = d3 ? rdata3  : rdata;
      ph = (c == 0) ? 0 : (c <= last_lo) ? 1 : (c <= last_hi) ? 2 : 3;
      check_eq($sformatf("%s c%0d ready", name, c), {31'd0, g_ready}, {31'd0, ph == 3});
      if (ph == 1 || ph == 2) begin
        check_eq($sformatf("%s c%0d addr", name, c), {14'd0, g_addr},
                 {14'd0, (ph == 2) ? (lo | 18'd1) : lo});
        check_eq($sformatf("%s c%0d oe", name, c), {31'd0, g_oe}, {31'd0, wr});
        check_eq($sformatf("%s c%0d we_n", name, c), {31'd0, g_we_n},
                 {31'd0, !(wr && c != last_lo && c != last_hi)});
        if (wr)
          check_eq($sformatf("%s c%0d dq_out", name, c), {16'd0, g_dq},
                   {16'd0, (ph == 1) ? wd[15:0] : wd[31:16]});
      end else begin
        check_eq($sformatf("%s c%0d oe", name, c), {31'd0, g_oe}, 32'd0);
        check_eq($sformatf("%s c%0d we_n", name, c), {31'd0, g_we_n}, 32'd1);
      end
      if (ph == 3 && !wr)
        check_eq($sformatf("%s c%0d read_data", name, c), g_rd, exp_rd);
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]  = '0;
      mem3[i] = '0;
    end
    mem[4] = 16'h5678;
    mem[5] = 16'h1234;

    // reset with no request
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst ready", {31'd0, ready}, 32'd1);
      check_eq("rst we_n", {31'd0, we_n}, 32'd1);
      check_eq("rst oe", {31'd0, oe}, 32'd0);
      check_eq("rst read_data", rdata, 32'd0);
      check_eq("rst sram_addr", {14'd0, s_addr}, 32'd0);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle ready", {31'd0, ready}, 32'd1);
    next_cycle();

    access("rd1032", 1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 1, 18'd4, 32'h12345678);
    r_en = 1'b0;
    @(negedge clk);
    check_eq("post-rd ready", {31'd0, ready}, 32'd1);
    check_eq("post-rd read_data", rdata, 32'h12345678);
    next_cycle();

    access("wr1028", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1, 18'd2, 32'd0);
    w_en = 1'b0;
    check_eq("mem[2]", {16'd0, mem[2]}, 32'h0000BEEF);
    check_eq("mem[3]", {16'd0, mem[3]}, 32'h0000DEAD);
    check_eq("post-wr read_data", rdata, 32'h12345678);
    next_cycle();

    // back-to-back: write request presented in the cycle right after DONE
    access("b2b rd", 1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 1, 18'd4, 32'h12345678);
    access("b2b wr", 1'b0, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 1, 18'd6, 32'd0);
    w_en = 1'b0;
    check_eq("b2b mem[6]", {16'd0, mem[6]}, 32'h0000F00D);
    check_eq("b2b mem[7]", {16'd0, mem[7]}, 32'h0000CAFE);
    check_eq("b2b read_data", rdata, 32'h12345678);
    next_cycle();

    access("rd1028", 1'b0, 1'b1, 1'b0, 32'd1028, 32'd0, 1, 18'd2, 32'hDEADBEEF);
    r_en = 1'b0;
    next_cycle();

    // reset in cycle 2 of a write, request kept asserted
    w_en = 1'b1; addr = 32'd1040; wdata = 32'h11112222;
    @(negedge clk);
    check_eq("mid c0 ready", {31'd0, ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("mid c1 we_n", {31'd0, we_n}, 32'd0);
    check_eq("mid c1 oe", {31'd0, oe}, 32'd1);
    check_eq("mid c1 addr", {14'd0, s_addr}, 32'd8);
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("mid rst we_n", {31'd0, we_n}, 32'd1);
    check_eq("mid rst oe", {31'd0, oe}, 32'd0);
    check_eq("mid rst ready", {31'd0, ready}, 32'd0);
    check_eq("mid rst read_data", rdata, 32'd0);
    next_cycle();
    rst = 1'b1;
    access("restart wr", 1'b0, 1'b0, 1'b1, 32'd1040, 32'h11112222, 1, 18'd8, 32'd0);
    w_en = 1'b0;
    check_eq("restart mem[8]", {16'd0, mem[8]}, 32'h00002222);
    check_eq("restart mem[9]", {16'd0, mem[9]}, 32'h00001111);
    next_cycle();

    // WAIT_CYCLES=3: both enables high performs a write, then read it back
    access("w3 both", 1'b1, 1'b1, 1'b1, 32'd1024, 32'hA5A55A5A, 3, 18'd0, 32'd0);
    r_en3 = 1'b0; w_en3 = 1'b0;
    check_eq("w3 mem[0]", {16'd0, mem3[0]}, 32'h00005A5A);
    check_eq("w3 mem[1]", {16'd0, mem3[1]}, 32'h0000A5A5);
    check_eq("w3 read_data", rdata3, 32'd0);
    next_cycle();
    access("w3 rd", 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 3, 18'd0, 32'hA5A55A5A);
    r_en3 = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
